// File: rtl/slavespi_kbdmus.sv
// SPI slave from the board AVR: decodes keyboard-matrix and mouse frames and
// presents them as parallel data plus one-cycle strobes in the fclk domain.
module slavespi_kbdmus #(
    parameter logic [7:0] KBD_CMD    = 8'h10,
    parameter logic [7:0] MUSX_CMD   = 8'h20,
    parameter logic [7:0] MUSY_CMD   = 8'h21,
    parameter logic [7:0] MUSBTN_CMD = 8'h22
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        spics_n,
    input  logic        spick,
    input  logic        spido,
    output logic [39:0] kbd_in,
    output logic        kbd_stb,
    output logic [7:0]  mus_in,
    output logic        mus_xstb,
    output logic        mus_ystb,
    output logic        mus_btnstb,
    output logic        frame_err
);

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_KBD, ST_MUS, ST_IGNORE} state_t;
    typedef enum logic [1:0] {SEL_X, SEL_Y, SEL_BTN} mus_sel_t;

    // bit0 = s1, bit1 = s2, bit2 = s3
    logic [2:0] cs_sync, ck_sync, do_sync;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync <= 3'b111;
            ck_sync <= 3'b000;
            do_sync <= 3'b000;
        end else begin
            cs_sync <= {cs_sync[1:0], spics_n};
            ck_sync <= {ck_sync[1:0], spick};
            do_sync <= {do_sync[1:0], spido};
        end
    end

    logic ck_rise, cs_fall, cs_rise, bit_in;
    assign ck_rise = ck_sync[1] & ~ck_sync[2];
    assign cs_fall = ~cs_sync[1] & cs_sync[2];
    assign cs_rise = cs_sync[1] & ~cs_sync[2];
    assign bit_in  = do_sync[1];

    state_t     state, state_d;
    mus_sel_t   mus_sel;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt;
    logic [2:0] byte_cnt;
    logic [31:0] stage;

    logic       byte_done;
    logic [7:0] new_byte;
    assign byte_done = ck_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);
    assign new_byte  = {shift_q[6:0], bit_in};

    logic kbd_commit, mus_commit, err, clr_cnt;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d    = state;
        kbd_commit = 1'b0;
        mus_commit = 1'b0;
        err        = 1'b0;
        clr_cnt    = 1'b0;
        if (cs_fall) begin
            state_d = ST_CMD;
            clr_cnt = 1'b1;
        end else begin
            case (state)
                ST_CMD: begin
                    if (byte_done) begin
                        if (new_byte == KBD_CMD)
                            state_d = ST_KBD;
                        else if (new_byte == MUSX_CMD || new_byte == MUSY_CMD ||
                                 new_byte == MUSBTN_CMD)
                            state_d = ST_MUS;
                        else
                            state_d = ST_IGNORE;
                    end
                end
                ST_KBD: begin
                    if (byte_done && byte_cnt == 3'd4) begin
                        kbd_commit = 1'b1;
                        state_d    = ST_IGNORE;
                    end
                end
                ST_MUS: begin
                    if (byte_done) begin
                        mus_commit = 1'b1;
                        state_d    = ST_IGNORE;
                    end
                end
                default: ;
            endcase
            // A commit landing together with CS rise still counts as a good frame
            if (cs_rise) begin
                state_d = ST_IDLE;
                clr_cnt = 1'b1;
                if (!kbd_commit && !mus_commit &&
                    ((state == ST_CMD && bit_cnt != 3'd0) ||
                     state == ST_KBD || state == ST_MUS))
                    err = 1'b1;
            end
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= 8'h00;
            bit_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
            mus_sel  <= SEL_X;
            stage    <= 32'h0;
        end else if (clr_cnt) begin
            shift_q  <= 8'h00;
            bit_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
        end else if (ck_rise && state != ST_IDLE) begin
            shift_q <= new_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
                if (state == ST_CMD) begin
                    byte_cnt <= 3'd0;
                    if (new_byte == MUSX_CMD)      mus_sel <= SEL_X;
                    else if (new_byte == MUSY_CMD) mus_sel <= SEL_Y;
                    else                           mus_sel <= SEL_BTN;
                end else if (state == ST_KBD) begin
                    byte_cnt <= byte_cnt + 3'd1;
                    case (byte_cnt)
                        3'd0:    stage[31:24] <= new_byte;
                        3'd1:    stage[23:16] <= new_byte;
                        3'd2:    stage[15:8]  <= new_byte;
                        3'd3:    stage[7:0]   <= new_byte;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Output register stage: data and strobes leave together
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            kbd_in     <= 40'h0;
            mus_in     <= 8'h00;
            kbd_stb    <= 1'b0;
            mus_xstb   <= 1'b0;
            mus_ystb   <= 1'b0;
            mus_btnstb <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            kbd_stb    <= kbd_commit;
            mus_xstb   <= mus_commit && (mus_sel == SEL_X);
            mus_ystb   <= mus_commit && (mus_sel == SEL_Y);
            mus_btnstb <= mus_commit && (mus_sel == SEL_BTN);
            frame_err  <= err;
            if (kbd_commit) kbd_in <= {stage, new_byte};
            if (mus_commit) mus_in <= new_byte;
        end
    end

endmodule

// File: tb/tb_slavespi_kbdmus.sv
// Scoreboard bench for slavespi_kbdmus: a frame-level model queues expected
// strobe events, a monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_slavespi_kbdmus;

    logic        fclk = 1'b0;
    logic        rst_n, spics_n, spick, spido;
    logic [39:0] kbd_in;
    logic        kbd_stb, mus_xstb, mus_ystb, mus_btnstb, frame_err;
    logic [7:0]  mus_in;

    always #5 fclk = ~fclk;

    slavespi_kbdmus dut (
        .fclk(fclk), .rst_n(rst_n), .spics_n(spics_n), .spick(spick), .spido(spido),
        .kbd_in(kbd_in), .kbd_stb(kbd_stb), .mus_in(mus_in), .mus_xstb(mus_xstb),
        .mus_ystb(mus_ystb), .mus_btnstb(mus_btnstb), .frame_err(frame_err)
    );

    // kind: 0 keyboard, 1 mouse X, 2 mouse Y, 3 mouse buttons, 4 frame error
    typedef struct {
        int          kind;
        logic [39:0] data;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  fq[$];
    logic [39:0] model_kbd;
    logic [7:0]  model_mus;
    longint      last_rise_t;
    int          checks, failures;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        int   n, kind;
        exp_t e;
        logic [39:0] d;
        forever begin
            @(negedge fclk);
            if (rst_n) begin
                n = int'(kbd_stb) + int'(mus_xstb) + int'(mus_ystb) + int'(mus_btnstb) + int'(frame_err);
                if (n > 0) begin
                    check("one_strobe", (n > 1) ? 40'd1 : 40'd0, 40'd0);
                    kind = kbd_stb ? 0 : mus_xstb ? 1 : mus_ystb ? 2 : mus_btnstb ? 3 : 4;
                    d = (kind >= 1 && kind <= 3) ? {32'h0, mus_in} : kbd_in;
                    if (expq.size() == 0) begin
                        check("unexpected_event", 40'(kind), 40'd99);
                    end else begin
                        e = expq.pop_front();
                        check("event_kind", 40'(kind), 40'(e.kind));
                        check("event_data", d, e.data);
                        if (e.kind < 4)
                            check("strobe_latency", 40'($time - last_rise_t), 40'd30);
                    end
                end
            end
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            spido = b[7-i];
            repeat (4) @(negedge fclk);
            spick = 1'b1;
            last_rise_t = $time;
            repeat (4) @(negedge fclk);
            spick = 1'b0;
        end
    endtask

    task automatic send_frame(input int extra_bits, input logic [7:0] extra_val);
        @(negedge fclk);
        spics_n = 1'b0;
        repeat (4) @(negedge fclk);
        foreach (fq[i]) send_bits(fq[i], 8);
        if (extra_bits > 0) send_bits(extra_val, extra_bits);
        repeat (4) @(negedge fclk);
        spics_n = 1'b1;
        repeat (8) @(negedge fclk);
    endtask

    // Frame-level reference: what a frame of whole bytes (plus trailing bits) must produce
    task automatic model_frame(input int extra_bits);
        int   nd;
        exp_t e;
        if (fq.size() == 0) begin
            if (extra_bits > 0) begin e.kind = 4; e.data = model_kbd; expq.push_back(e); end
            return;
        end
        nd = fq.size() - 1;
        if (fq[0] == 8'h10) begin
            if (nd >= 5) begin
                model_kbd = {fq[1], fq[2], fq[3], fq[4], fq[5]};
                e.kind = 0; e.data = model_kbd;
            end else begin
                e.kind = 4; e.data = model_kbd;
            end
            expq.push_back(e);
        end else if (fq[0] == 8'h20 || fq[0] == 8'h21 || fq[0] == 8'h22) begin
            if (nd >= 1) begin
                model_mus = fq[1];
                e.kind = int'(fq[0] - 8'h1F);
                e.data = {32'h0, model_mus};
            end else begin
                e.kind = 4; e.data = model_kbd;
            end
            expq.push_back(e);
        end
    endtask

    task automatic run_frame(input int extra_bits, input logic [7:0] extra_val);
        model_frame(extra_bits);
        send_frame(extra_bits, extra_val);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_kbd_in"}, kbd_in, 40'h0);
        check({tag, "_mus_in"}, {32'h0, mus_in}, 40'h0);
        check({tag, "_strobes"}, {35'h0, kbd_stb, mus_xstb, mus_ystb, mus_btnstb, frame_err}, 40'h0);
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && expq.size() != 0; t++) @(negedge fclk);
        check("drain_pending", 40'(expq.size()), 40'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        model_kbd = 40'h0; model_mus = 8'h0; last_rise_t = 0;
        rst_n = 1'b0; spics_n = 1'b1; spick = 1'b0; spido = 1'b0;
        repeat (5) @(negedge fclk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        fork monitor(); join_none
        repeat (5) @(negedge fclk);

        fq = '{8'h10, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10}; run_frame(0, 8'h00);
        fq = '{8'h20, 8'h7F}; run_frame(0, 8'h00);
        fq = '{8'h21, 8'h80}; run_frame(0, 8'h00);
        fq = '{8'h22, 8'h07}; run_frame(0, 8'h00);
        fq = '{8'h10, 8'hAA, 8'hBB}; run_frame(0, 8'h00);
        fq = '{8'h33, 8'h55, 8'h66}; run_frame(0, 8'h00);
        fq = '{8'h20, 8'h11, 8'h22}; run_frame(0, 8'h00);
        drain();
        check("kbd_hold", kbd_in, 40'h0102040810);
        check("mus_hold", {32'h0, mus_in}, 40'h11);

        // reset in the middle of a keyboard frame
        @(negedge fclk);
        spics_n = 1'b0;
        repeat (4) @(negedge fclk);
        send_bits(8'h10, 8);
        send_bits(8'hAA, 8);
        send_bits(8'hBB, 3);
        rst_n = 1'b0; spics_n = 1'b1;
        repeat (2) @(negedge fclk);
        check_reset_outputs("midframe_reset");
        model_kbd = 40'h0; model_mus = 8'h0;
        rst_n = 1'b1;
        repeat (4) @(negedge fclk);
        fq = '{8'h10, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF}; run_frame(0, 8'h00);
        drain();
        check("kbd_after_reset", kbd_in, 40'hFF00FF00FF);

        // chip select bounced before any bits, then a button frame
        for (int k = 0; k < 2; k++) begin
            @(negedge fclk); spics_n = 1'b0;
            repeat (4) @(negedge fclk); spics_n = 1'b1;
        end
        fq = '{8'h22, 8'h05}; run_frame(0, 8'h00);
        drain();
        check("mus_btn_after_restart", {32'h0, mus_in}, 40'h05);

        // randomized frames
        for (int f = 0; f < 24; f++) begin
            int sel, nd, xb;
            logic [7:0] cmd;
            sel = $urandom_range(0, 4);
            case (sel)
                0: cmd = 8'h10;
                1: cmd = 8'h20;
                2: cmd = 8'h21;
                3: cmd = 8'h22;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            nd = (cmd == 8'h10) ? $urandom_range(0, 6) : $urandom_range(0, 2);
            fq = {};
            if ($urandom_range(0, 9) != 0) begin
                fq.push_back(cmd);
                for (int j = 0; j < nd; j++) fq.push_back(8'($urandom_range(0, 255)));
            end
            xb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            run_frame(xb, 8'($urandom_range(0, 255)));
        end
        drain();
        check("final_kbd_in", kbd_in, model_kbd);
        check("final_mus_in", {32'h0, mus_in}, {32'h0, model_mus});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
